// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined float adder: default format, class encoding
// and a width-generic helper that packs {sign, exponent, fraction} into a word.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_MAX_W = 64;

  localparam logic [FP_EXP_W-1:0] FP_EXP_ONES  = '1;
  localparam logic [FP_W-1:0]     FP_CANON_NAN = {1'b0, FP_EXP_ONES, 1'b1, {(FP_MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Fields wider than their format are masked, so callers may pass zero-extended values.
  function automatic logic [FP_MAX_W-1:0] fp_pack(
    input logic                sign,
    input logic [FP_MAX_W-1:0] exp,
    input logic [FP_MAX_W-1:0] frac,
    input int                  exp_w,
    input int                  man_w
  );
    logic [FP_MAX_W-1:0] mask_e;
    logic [FP_MAX_W-1:0] mask_m;
    mask_e = ~({FP_MAX_W{1'b1}} << exp_w);
    mask_m = ~({FP_MAX_W{1'b1}} << man_w);
    return ({{(FP_MAX_W-1){1'b0}}, sign} << (exp_w + man_w))
         | ((exp & mask_e) << man_w)
         | (frac & mask_m);
  endfunction

endpackage

// File: rtl/fp_add_pipe_lzc.sv
// Leading-zero counter used by the normaliser; an all-zero input returns N.
module fp_lzc #(
  parameter int N = 27
) (
  input  logic [N-1:0]             i_data,
  output logic [$clog2(N+1)-1:0]   o_count
);

  localparam int CW = $clog2(N+1);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (i_data[i]) o_count = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Pipelined float adder/subtractor: input capture, align, add, normalise/round.
// Valid/ready: a transfer happens on valid&&ready at the rising edge; one global stall.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       A,
  input  logic [EXP_W+MAN_W:0]       B,
  input  logic                       Sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       Sum,
  output logic                       Overflow,
  output logic                       Zero,
  output logic                       Inexact,
  output logic                       Invalid
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW  = EXP_W + 2;
  localparam int MW  = MAN_W + 4;
  localparam int LZW = $clog2(MW + 1);

  localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
  localparam logic signed [EW-1:0] EXP_MAX   = {2'b00, EXP_ONES};
  localparam logic signed [EW-1:0] EXP_ZERO  = '0;
  localparam logic [W-1:0]         CANON_NAN = W'(fp_pack(1'b0, FP_MAX_W'(EXP_ONES),
                                                         FP_MAX_W'(1) << (MAN_W - 1), EXP_W, MAN_W));
  localparam logic [W-1:0]         INF_POS   = W'(fp_pack(1'b0, FP_MAX_W'(EXP_ONES),
                                                         '0, EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)            return CLS_ZERO;
    else if (e != EXP_ONES) return CLS_NORM;
    else if (f == '0)       return CLS_INF;
    else                    return CLS_NAN;
  endfunction

  logic w_adv;
  logic r_out_valid;

  assign w_adv    = !(r_out_valid && !out_ready);
  assign in_ready = w_adv;

  // ---------------- input capture ----------------
  logic         r0_valid;
  logic [W-1:0] r0_a, r0_b;
  logic         r0_sub;

  // ---------------- stage 1: classify and align ----------------
  logic                   w_sa, w_sb;
  logic [EXP_W-1:0]       w_ea, w_eb;
  logic [MAN_W-1:0]       w_fa, w_fb;
  fp_class_e              w_cls_a, w_cls_b;
  logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
  logic [MAN_W:0]         w_sig_a, w_sig_b, w_sig_l, w_sig_s;
  logic                   w_a_big, w_sign_l;
  logic [EXP_W-1:0]       w_exp_l, w_exp_s, w_shift;
  logic [MW-1:0]          w_ext_s, w_lost_mask, w_align_s;
  logic                   w_inf_a, w_inf_b, w_spec_inv, w_spec;
  logic [W-1:0]           w_spec_word;

  assign w_sa    = r0_a[W-1];
  assign w_sb    = r0_b[W-1] ^ r0_sub;
  assign w_ea    = r0_a[W-2 -: EXP_W];
  assign w_eb    = r0_b[W-2 -: EXP_W];
  assign w_fa    = r0_a[MAN_W-1:0];
  assign w_fb    = r0_b[MAN_W-1:0];
  assign w_cls_a = classify(w_ea, w_fa);
  assign w_cls_b = classify(w_eb, w_fb);

  // Denormals are flushed, so their fraction must not influence the magnitude compare.
  assign w_mag_a = {w_ea, (w_cls_a == CLS_ZERO) ? {MAN_W{1'b0}} : w_fa};
  assign w_mag_b = {w_eb, (w_cls_b == CLS_ZERO) ? {MAN_W{1'b0}} : w_fb};
  assign w_sig_a = (w_cls_a == CLS_ZERO) ? '0 : {1'b1, w_fa};
  assign w_sig_b = (w_cls_b == CLS_ZERO) ? '0 : {1'b1, w_fb};

  assign w_a_big  = (w_mag_a >= w_mag_b);
  assign w_sign_l = w_a_big ? w_sa : w_sb;
  assign w_exp_l  = w_a_big ? w_ea : w_eb;
  assign w_exp_s  = w_a_big ? w_eb : w_ea;
  assign w_sig_l  = w_a_big ? w_sig_a : w_sig_b;
  assign w_sig_s  = w_a_big ? w_sig_b : w_sig_a;
  assign w_shift  = w_exp_l - w_exp_s;

  // Oversized shifts leave only the sticky bit, which collects everything shifted out.
  assign w_ext_s     = {w_sig_s, 3'b000};
  assign w_lost_mask = ~({MW{1'b1}} << w_shift);
  assign w_align_s   = (w_ext_s >> w_shift) | {{(MW-1){1'b0}}, |(w_ext_s & w_lost_mask)};

  assign w_inf_a     = (w_cls_a == CLS_INF);
  assign w_inf_b     = (w_cls_b == CLS_INF);
  assign w_spec_inv  = (w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN)
                    || (w_inf_a && w_inf_b && (w_sa != w_sb));
  assign w_spec      = w_spec_inv || w_inf_a || w_inf_b;
  assign w_spec_word = w_spec_inv ? CANON_NAN : {(w_inf_a ? w_sa : w_sb), INF_POS[W-2:0]};

  logic                  r1_valid, r1_sign, r1_eff_sub, r1_spec, r1_spec_inv;
  logic signed [EW-1:0]  r1_exp;
  logic [MW-1:0]         r1_man_l, r1_man_s;
  logic [W-1:0]          r1_spec_word;

  // ---------------- stage 2: add / subtract magnitudes ----------------
  logic [MW:0] w_sum;

  assign w_sum = r1_eff_sub ? ({1'b0, r1_man_l} - {1'b0, r1_man_s})
                            : ({1'b0, r1_man_l} + {1'b0, r1_man_s});

  logic                  r2_valid, r2_sign, r2_eff_sub, r2_spec, r2_spec_inv;
  logic signed [EW-1:0]  r2_exp;
  logic [MW:0]           r2_sum;
  logic [W-1:0]          r2_spec_word;

  // ---------------- stage 3: normalise and round ----------------
  logic [LZW-1:0]        w_lz;
  logic                  w_carry, w_sum_zero;
  logic [MW-1:0]         w_norm;
  logic signed [EW-1:0]  w_exp_n, w_exp_f;
  logic                  w_rnd_up, w_rnd_inx, w_rcarry;
  logic [MAN_W+1:0]      w_mant_r;
  logic [MAN_W-1:0]      w_frac_f;
  logic [W-1:0]          w_res;
  logic                  w_ovf, w_zero, w_inx, w_inv;

  fp_lzc #(.N(MW)) u_lzc (
    .i_data  (r2_sum[MW-1:0]),
    .o_count (w_lz)
  );

  assign w_carry    = r2_sum[MW];
  assign w_sum_zero = (r2_sum == '0);
  assign w_norm     = w_carry ? {r2_sum[MW:2], r2_sum[1] | r2_sum[0]}
                              : (r2_sum[MW-1:0] << w_lz);
  assign w_exp_n    = w_carry ? (r2_exp + EW'(1)) : (r2_exp - EW'(w_lz));

  // Layout of w_norm: hidden, fraction, guard, round, sticky.
  assign w_rnd_inx = w_norm[2] | w_norm[1] | w_norm[0];
  assign w_rnd_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mant_r  = {1'b0, w_norm[MW-1:3]} + (MAN_W+2)'(w_rnd_up);
  assign w_rcarry  = w_mant_r[MAN_W+1];
  assign w_frac_f  = w_rcarry ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
  assign w_exp_f   = w_exp_n + EW'(w_rcarry);

  always_comb begin
    w_res  = '0;
    w_ovf  = 1'b0;
    w_zero = 1'b0;
    w_inx  = 1'b0;
    w_inv  = 1'b0;
    if (r2_spec) begin
      w_res = r2_spec_word;
      w_inv = r2_spec_inv;
    end else if (w_sum_zero) begin
      // Only (-0)+(-0) keeps a negative zero; any cancellation is +0.
      w_res  = {(r2_eff_sub ? 1'b0 : r2_sign), {(W-1){1'b0}}};
      w_zero = 1'b1;
    end else if (w_exp_f >= EXP_MAX) begin
      w_res = {r2_sign, INF_POS[W-2:0]};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_exp_f <= EXP_ZERO) begin
      w_zero = 1'b1;
      w_inx  = 1'b1;
    end else begin
      w_res = W'(fp_pack(r2_sign, FP_MAX_W'(w_exp_f[EXP_W-1:0]), FP_MAX_W'(w_frac_f), EXP_W, MAN_W));
      w_inx = w_rnd_inx;
    end
  end

  // ---------------- registers ----------------
  logic [W-1:0] r_sum;
  logic         r_ovf, r_zero, r_inx, r_inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_valid    <= 1'b0;
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_inx       <= 1'b0;
      r_inv       <= 1'b0;
    end else if (w_adv) begin
      r0_valid    <= in_valid;
      r1_valid    <= r0_valid;
      r2_valid    <= r1_valid;
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_sum  <= w_res;
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
        r_inx  <= w_inx;
        r_inv  <= w_inv;
      end
    end
  end

  // Datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      if (in_valid) begin
        r0_a   <= A;
        r0_b   <= B;
        r0_sub <= Sub;
      end
      r1_sign      <= w_sign_l;
      r1_eff_sub   <= (w_sa != w_sb);
      r1_exp       <= {2'b00, w_exp_l};
      r1_man_l     <= {w_sig_l, 3'b000};
      r1_man_s     <= w_align_s;
      r1_spec      <= w_spec;
      r1_spec_inv  <= w_spec_inv;
      r1_spec_word <= w_spec_word;
      r2_sign      <= r1_sign;
      r2_eff_sub   <= r1_eff_sub;
      r2_exp       <= r1_exp;
      r2_sum       <= w_sum;
      r2_spec      <= r1_spec;
      r2_spec_inv  <= r1_spec_inv;
      r2_spec_word <= r1_spec_word;
    end
  end

  assign out_valid = r_out_valid;
  assign Sum       = r_sum;
  assign Overflow  = r_ovf;
  assign Zero      = r_zero;
  assign Inexact   = r_inx;
  assign Invalid   = r_inv;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: vector table, backpressure, latency and mid-stream reset.
module tb_fp_add_pipe;
  import fp_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, Sub, out_valid, out_ready;
  logic         Overflow, Zero, Inexact, Invalid;
  logic [W-1:0] A, B, Sum;
  logic [3:0]   flags;

  assign flags = {Overflow, Zero, Inexact, Invalid};

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Overflow  (Overflow),
    .Zero      (Zero),
    .Inexact   (Inexact),
    .Invalid   (Invalid)
  );

  // flags = {Overflow, Zero, Inexact, Invalid}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  logic [W+3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output monitor: scoreboard pop on transfer, stability check while held.
  logic [W+3:0] held;
  logic         held_v    = 1'b0;
  logic         saw_stall = 1'b0;
  logic [W+3:0] e;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid) begin
        if (held_v) check("hold_stable", {Sum, flags}, held);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", {Sum, flags}, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("sum", Sum, e[W+3:4]);
            check("flags", flags, e[3:0]);
          end
          held_v = 1'b0;
        end else begin
          held   = {Sum, flags};
          held_v = 1'b1;
        end
      end
    end
  end

  task automatic issue(input int idx);
    A        = vecs[idx].a;
    B        = vecs[idx].b;
    Sub      = vecs[idx].sub;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        exp_q.push_back({vecs[idx].sum, vecs[idx].flags});
        return;
      end
      @(posedge clk); #1;
    end
    check("issue_timeout", 1, 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic latency_check(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, lat, 3);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int stale;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0100};
    vecs[2]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010};
    vecs[4]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0010};
    vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0001};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0100};
    vecs[8]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
    vecs[9]  = '{32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 4'b0000};
    vecs[10] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    vecs[11] = '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000};
    vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
    vecs[13] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0110};
    vecs[14] = '{32'h3FC00000, 32'h40000000, 1'b0, 32'h40600000, 4'b0000};
    vecs[15] = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000};
    vecs[16] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0010};
    vecs[17] = '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000};
    vecs[18] = '{32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 4'b0010};
    vecs[19] = '{32'h7F000000, 32'h3F800000, 1'b1, 32'h7F000000, 4'b0010};
    vecs[20] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0100};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Sub       = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", Sum, 0);
    check("rst_flags", flags, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_out_valid", out_valid, 0);

    // Single op: latency from accept edge to out_valid.
    issue(0);
    in_valid = 1'b0;
    latency_check("latency");
    drain();

    // Whole table back-to-back with the consumer always ready.
    for (int i = 0; i < NV; i++) issue(i);
    in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for a window while six ops stream in.
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) issue(i);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("in_ready_dropped", saw_stall, 1);

    // Mid-stream reset with one result valid and three operations in flight.
    for (int i = 8; i < 12; i++) issue(i);
    in_valid = 1'b0;
    check("pre_reset_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", Sum, 0);
    check("mid_rst_flags", flags, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1;
    end
    check("no_stale_after_reset", stale, 0);
    issue(2);
    in_valid = 1'b0;
    latency_check("latency_after_reset");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
